// File: rtl/rx_ptp_parse.sv
// XGMII receive-side PTP classifier with a 1-cycle leading tap and a 4-cycle data tap.
// Optional: define PTP_RX_VLAN_PARSE_EN to look through a single 802.1Q tag.
module rx_ptp_parse (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic        rx_clk_en_i,
  input  logic [63:0] rxd_i,
  input  logic [7:0]  rxc_i,
  output logic [63:0] rxd_p3_o,
  output logic [7:0]  rxc_p3_o,
  output logic [63:0] rxd_o,
  output logic [7:0]  rxc_o,
  output logic        get_sfd_pulse_o,
  output logic        is_ptp_message_o,
  output logic [3:0]  ptp_messageType_o,
  output logic        frame_err_o
);

  localparam logic [63:0] IdleData  = 64'h0707070707070707;
  localparam logic [7:0]  IdleCtrl  = 8'hFF;
  localparam logic [63:0] StartData = 64'hD5555555555555FB;
  localparam logic [15:0] PtpEtype  = 16'h88F7;
  localparam int          TapDepth  = 4;

`ifdef PTP_RX_VLAN_PARSE_EN
  localparam logic [15:0] VlanEtype = 16'h8100;
  typedef enum logic [2:0] {StIdle, StW1, StW2, StVlan, StBody} state_e;
`else
  typedef enum logic [2:0] {StIdle, StW1, StW2, StBody} state_e;
`endif

  // Delay line: tap 0 is the leading (p3) output, the last tap feeds rxd_o.
  logic [63:0] rxd_tap_q [TapDepth];
  logic [7:0]  rxc_tap_q [TapDepth];

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      for (int i = 0; i < TapDepth; i++) begin
        rxd_tap_q[i] <= IdleData;
        rxc_tap_q[i] <= IdleCtrl;
      end
    end else if (rx_clk_en_i) begin
      rxd_tap_q[0] <= rxd_i;
      rxc_tap_q[0] <= rxc_i;
      for (int i = 1; i < TapDepth; i++) begin
        rxd_tap_q[i] <= rxd_tap_q[i-1];
        rxc_tap_q[i] <= rxc_tap_q[i-1];
      end
    end
  end

  assign rxd_p3_o = rxd_tap_q[0];
  assign rxc_p3_o = rxc_tap_q[0];
  assign rxd_o    = rxd_tap_q[TapDepth-1];
  assign rxc_o    = rxc_tap_q[TapDepth-1];

  // Word decode on the live input
  logic        start_word;
  logic        has_ctrl;
  logic        has_term;
  logic        has_err;
  logic [15:0] w2_etype;
  logic [3:0]  w2_msg_type;

  always_comb begin
    has_term = 1'b0;
    has_err  = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (rxc_i[l] && (rxd_i[8*l +: 8] == 8'hFD)) has_term = 1'b1;
      if (rxc_i[l] && (rxd_i[8*l +: 8] == 8'hFE)) has_err  = 1'b1;
    end
  end

  assign start_word  = (rxc_i == 8'h01) && (rxd_i == StartData);
  assign has_ctrl    = |rxc_i;
  assign w2_etype    = {rxd_i[39:32], rxd_i[47:40]};
  assign w2_msg_type = rxd_i[51:48];

`ifdef PTP_RX_VLAN_PARSE_EN
  logic [15:0] w3_etype;
  logic [3:0]  w3_msg_type;
  assign w3_etype    = {rxd_i[7:0], rxd_i[15:8]};
  assign w3_msg_type = rxd_i[19:16];
`endif

  state_e     state_q, state_d;
  logic       pulse_q, pulse_d;
  logic       is_ptp_q, is_ptp_d;
  logic [3:0] msg_type_q, msg_type_d;
  logic       err_q, err_d;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q    <= StIdle;
      pulse_q    <= 1'b0;
      is_ptp_q   <= 1'b0;
      msg_type_q <= 4'h0;
      err_q      <= 1'b0;
    end else if (rx_clk_en_i) begin
      state_q    <= state_d;
      pulse_q    <= pulse_d;
      is_ptp_q   <= is_ptp_d;
      msg_type_q <= msg_type_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pulse_d    = 1'b0;
    is_ptp_d   = is_ptp_q;
    msg_type_d = msg_type_q;
    err_d      = err_q;
    if (start_word) begin
      // A start word always (re)opens a frame, even mid-frame.
      state_d    = StW1;
      pulse_d    = 1'b1;
      is_ptp_d   = 1'b0;
      msg_type_d = 4'h0;
      err_d      = 1'b0;
    end else begin
      if ((state_q != StIdle) && has_err) err_d = 1'b1;
      case (state_q)
        StIdle: state_d = StIdle;
        StW1:   state_d = has_ctrl ? StIdle : StW2;
        StW2: begin
          if (has_ctrl) begin
            state_d = StIdle;
          end else if (w2_etype == PtpEtype) begin
            state_d    = StBody;
            is_ptp_d   = 1'b1;
            msg_type_d = w2_msg_type;
`ifdef PTP_RX_VLAN_PARSE_EN
          end else if (w2_etype == VlanEtype) begin
            state_d = StVlan;
`endif
          end else begin
            state_d = StBody;
          end
        end
`ifdef PTP_RX_VLAN_PARSE_EN
        StVlan: begin
          if (has_ctrl) begin
            state_d = StIdle;
          end else begin
            state_d = StBody;
            if (w3_etype == PtpEtype) begin
              is_ptp_d   = 1'b1;
              msg_type_d = w3_msg_type;
            end
          end
        end
`endif
        StBody:  state_d = has_term ? StIdle : StBody;
        default: state_d = StIdle;
      endcase
    end
  end

  assign get_sfd_pulse_o   = pulse_q;
  assign is_ptp_message_o  = is_ptp_q;
  assign ptp_messageType_o = msg_type_q;
  assign frame_err_o       = err_q;

endmodule

// File: tb/tb_rx_ptp_parse.sv
// Randomised frame-level bench for rx_ptp_parse; expectations come from a history-scan model.
`timescale 1ns/1ps
module tb_rx_ptp_parse;

  localparam logic [63:0] IdleD  = 64'h0707070707070707;
  localparam logic [63:0] StartD = 64'hD5555555555555FB;
`ifdef PTP_RX_VLAN_PARSE_EN
  localparam bit VlanEn = 1'b1;
`else
  localparam bit VlanEn = 1'b0;
`endif

  logic        rx_clk = 1'b0;
  logic        rx_rst_n = 1'b1;
  logic        rx_clk_en_i = 1'b0;
  logic [63:0] rxd_i = IdleD;
  logic [7:0]  rxc_i = 8'hFF;
  logic [63:0] rxd_p3_o, rxd_o;
  logic [7:0]  rxc_p3_o, rxc_o;
  logic        get_sfd_pulse_o, is_ptp_message_o, frame_err_o;
  logic [3:0]  ptp_messageType_o;

  rx_ptp_parse dut (
    .rx_clk            (rx_clk),
    .rx_rst_n          (rx_rst_n),
    .rx_clk_en_i       (rx_clk_en_i),
    .rxd_i             (rxd_i),
    .rxc_i             (rxc_i),
    .rxd_p3_o          (rxd_p3_o),
    .rxc_p3_o          (rxc_p3_o),
    .rxd_o             (rxd_o),
    .rxc_o             (rxc_o),
    .get_sfd_pulse_o   (get_sfd_pulse_o),
    .is_ptp_message_o  (is_ptp_message_o),
    .ptp_messageType_o (ptp_messageType_o),
    .frame_err_o       (frame_err_o)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } word_t;

  word_t hist[$];   // words consumed on enabled edges since the last reset
  int    n_cmp = 0;
  int    n_bad = 0;
  int    en_mode = 0;
  bit    en_phase = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane(input word_t w, input int l);
    return w.d[8*l +: 8];
  endfunction

  function automatic bit is_start(input word_t w);
    return (w.c == 8'h01) && (w.d == StartD);
  endfunction

  function automatic bit has_ctl_byte(input word_t w, input logic [7:0] b);
    for (int l = 0; l < 8; l++) if (w.c[l] && (lane(w, l) == b)) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs as a function of the consumed word history.
  task automatic model(output word_t p3, output word_t dly, output bit pulse, output bit ptp,
                       output logic [3:0] mt, output bit err);
    int n, s, hdr;
    logic [15:0] et;
    logic [7:0]  b;
    word_t idle;
    idle.d = IdleD;
    idle.c = 8'hFF;
    n = hist.size();
    p3  = (n >= 1) ? hist[n-1] : idle;
    dly = (n >= 4) ? hist[n-4] : idle;
    pulse = 1'b0; ptp = 1'b0; mt = 4'h0; err = 1'b0;
    s = -1;
    for (int i = n - 1; i >= 0; i--) begin
      if (is_start(hist[i])) begin
        s = i;
        break;
      end
    end
    if (s < 0) return;
    pulse = (s == n - 1);
    hdr = 2;
    if ((n - 1 >= s + 2) && (hist[s+1].c == 8'h00) && (hist[s+2].c == 8'h00)) begin
      et = {lane(hist[s+2], 4), lane(hist[s+2], 5)};
      if (et == 16'h88F7) begin
        ptp = 1'b1;
        b = lane(hist[s+2], 6);
        mt = b[3:0];
      end else if ((et == 16'h8100) && VlanEn) begin
        hdr = 3;
        if ((n - 1 >= s + 3) && (hist[s+3].c == 8'h00) &&
            ({lane(hist[s+3], 0), lane(hist[s+3], 1)} == 16'h88F7)) begin
          ptp = 1'b1;
          b = lane(hist[s+3], 2);
          mt = b[3:0];
        end
      end
    end
    for (int j = s + 1; j < n; j++) begin
      if (has_ctl_byte(hist[j], 8'hFE)) err = 1'b1;
      if ((j - s <= hdr) ? (hist[j].c != 8'h00) : has_ctl_byte(hist[j], 8'hFD)) break;
    end
  endtask

  task automatic compare_all();
    word_t p3, dl;
    bit pu, pt, er;
    logic [3:0] mt;
    model(p3, dl, pu, pt, mt, er);
    check_eq("rxd_p3", rxd_p3_o, p3.d);
    check_eq("rxc_p3", {56'h0, rxc_p3_o}, {56'h0, p3.c});
    check_eq("rxd_dly", rxd_o, dl.d);
    check_eq("rxc_dly", {56'h0, rxc_o}, {56'h0, dl.c});
    check_eq("sfd_pulse", {63'h0, get_sfd_pulse_o}, {63'h0, pu});
    check_eq("is_ptp", {63'h0, is_ptp_message_o}, {63'h0, pt});
    check_eq("msg_type", {60'h0, ptp_messageType_o}, {60'h0, mt});
    check_eq("frame_err", {63'h0, frame_err_o}, {63'h0, er});
  endtask

  // Present one word and hold it until an enabled edge consumes it.
  task automatic send(input logic [63:0] d, input logic [7:0] c);
    bit used;
    word_t w;
    used = 1'b0;
    rxd_i = d;
    rxc_i = c;
    while (!used) begin
      case (en_mode)
        0:       rx_clk_en_i = 1'b1;
        1: begin rx_clk_en_i = en_phase; en_phase = ~en_phase; end
        default: rx_clk_en_i = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge rx_clk);
      if (rx_clk_en_i) begin
        w.d = d;
        w.c = c;
        hist.push_back(w);
        used = 1'b1;
      end
      #1 compare_all();
    end
  endtask

  task automatic do_reset();
    rx_rst_n = 1'b0;
    hist.delete();
    #1 compare_all();
    repeat (2) @(posedge rx_clk);
    #1 compare_all();
    rx_rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // fault: 0 none, 1 /T/ word2 lane3, 2 /E/ in body, 3 reset at word2,
  //        4 restart after word1, 5 corrupted start, 6 /E/ in word1
  task automatic send_frame(input logic [15:0] etype, input logic [15:0] inner,
                            input logic [3:0] mt, input int body_words, input int fault);
    logic [63:0] d;
    logic [7:0]  c;
    int          l;
    if (fault == 4) begin
      send(StartD, 8'h01);
      send(rnd64(), 8'h00);
    end
    if (fault == 5) begin
      d = StartD;
      l = $urandom_range(0, 7);
      d[8*l +: 8] = d[8*l +: 8] ^ 8'h01;
      send(d, 8'h01);
    end else begin
      send(StartD, 8'h01);
    end
    d = rnd64(); c = 8'h00;
    if (fault == 6) begin
      l = $urandom_range(0, 7);
      d[8*l +: 8] = 8'hFE;
      c[l] = 1'b1;
    end
    send(d, c);
    d = rnd64(); c = 8'h00;
    d[39:32] = etype[15:8];
    d[47:40] = etype[7:0];
    d[51:48] = mt;
    if (fault == 1) begin
      d[31:24] = 8'hFD;
      c[3] = 1'b1;
    end
    if (fault == 3) begin
      rxd_i = d;
      rxc_i = c;
      do_reset();
      send(IdleD, 8'hFF);
      return;
    end
    send(d, c);
    if (etype == 16'h8100) begin
      d = rnd64();
      d[7:0]   = inner[15:8];
      d[15:8]  = inner[7:0];
      d[19:16] = mt;
      send(d, 8'h00);
    end
    for (int k = 0; k < body_words; k++) begin
      d = rnd64(); c = 8'h00;
      if ((fault == 2) && (k == 0)) begin
        l = $urandom_range(0, 7);
        d[8*l +: 8] = 8'hFE;
        c[l] = 1'b1;
      end
      send(d, c);
    end
    d = rnd64(); c = 8'h00;
    l = $urandom_range(0, 7);
    d[8*l +: 8] = 8'hFD;
    c[l] = 1'b1;
    for (int k = l + 1; k < 8; k++) begin
      d[8*k +: 8] = 8'h07;
      c[k] = 1'b1;
    end
    send(d, c);
    repeat ($urandom_range(0, 3)) send(IdleD, 8'hFF);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, n_bad %0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] et, inner;
    int          sel, fault;
    #2;
    do_reset();
    en_mode = 0;
    send_frame(16'h88F7, 16'h0000, 4'h0, 2, 0);
    send_frame(16'h88F7, 16'h0000, 4'h1, 1, 0);
    send_frame(16'h0800, 16'h0000, 4'h1, 3, 0);
    send_frame(16'h8100, 16'h88F7, 4'h8, 2, 0);
    send_frame(16'h88F7, 16'h0000, 4'h3, 2, 1);
    send_frame(16'h88F7, 16'h0000, 4'h2, 3, 2);
    send_frame(16'h88F7, 16'h0000, 4'h9, 1, 4);
    en_mode = 1;
    send_frame(16'h88F7, 16'h0000, 4'h0, 2, 0);
    send_frame(16'h88F7, 16'h0000, 4'h0, 2, 3);
    send_frame(16'h88F7, 16'h0000, 4'h0, 2, 0);
    for (int f = 0; f < 300; f++) begin
      en_mode = $urandom_range(0, 2);
      sel = $urandom_range(0, 4);
      case (sel)
        0:       begin et = 16'h88F7; inner = 16'h0000; end
        1:       begin et = 16'h0800; inner = 16'h0000; end
        2:       begin et = 16'h8100; inner = 16'h88F7; end
        3:       begin et = 16'h8100; inner = 16'h0800; end
        default: begin et = 16'($urandom); inner = 16'($urandom); end
      endcase
      fault = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      send_frame(et, inner, 4'($urandom), $urandom_range(1, 4), fault);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_ptp_parse.md
RX_PTP_PARSE -- requirements
Module: rx_ptp_parse

Interface
REQ-001 SHALL have parameter none; feature selection by macro only (see Configuration).
REQ-002 rx_clk  input  1  receive clock; all logic on rising edge.
REQ-003 rx_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_clk_en_i  input  1  clock enable; registers advance only when high.
REQ-005 rxd_i  input  64  XGMII data; lane 0 = bits[7:0] = first byte on wire.
REQ-006 rxc_i  input  8  XGMII control, bit n qualifies lane n.
REQ-007 rxd_p3_o / rxc_p3_o  output  64/8  input delayed 1 enabled cycle (leading tap).
REQ-008 rxd_o / rxc_o  output  64/8  input delayed 4 enabled cycles (trails p3 tap by 3).
REQ-009 get_sfd_pulse_o  output  1  one-cycle pulse when valid start word is on rxd_p3_o.
REQ-010 is_ptp_message_o  output  1  current frame is L2 PTP (ethertype 0x88F7).
REQ-011 ptp_messageType_o  output  4  low nibble of PTP header byte 0.
REQ-012 frame_err_o  output  1  current frame contained /E/ (0xFE with rxc bit set).

Function
REQ-013 Valid start word SHALL be rxc=8'h01, lane0=0xFB, lanes1-6=0x55, lane7=0xD5; any other start pattern ignored (no pulse, state IDLE).
REQ-014 Word index k: start word k=0; DA bytes 0-5 + SA 0-1 at k=1; SA 2-5, ethertype, PTP byte0 (lane 6) at k=2.
REQ-015 FSM states: IDLE, W1, W2, VLAN (macro only), BODY; IDLE->W1 on valid start; W1->W2; W2->BODY, or W2->VLAN when macro set and ethertype=0x8100; VLAN->BODY; BODY->IDLE on any lane with rxc bit set and byte 0xFD.
REQ-016 Untagged: if word2 lanes4-5 = 0x88,0xF7 then is_ptp_message_o=1 and ptp_messageType_o=word2 lane6[3:0], registered one cycle after word2 at rxd_i (start word +3 cycles).
REQ-017 Tagged (macro set): ethertype word3 lanes0-1, PTP byte0 word3 lane2; outputs registered start word +4 cycles.
REQ-018 Flags SHALL therefore be valid no later than the cycle the start word appears on rxd_o.
REQ-019 On get_sfd_pulse_o cycle, is_ptp_message_o, ptp_messageType_o, frame_err_o SHALL clear to 0; otherwise held until next pulse.
REQ-020 Terminate (/T/) or control byte in W1/W2/VLAN: return IDLE, is_ptp_message_o stays 0.
REQ-021 Valid start word in any non-IDLE state: restart at W1, emit pulse, clear flags.
REQ-022 /E/ seen in any non-IDLE state sets frame_err_o; does not change other flags.
REQ-023 rx_clk_en_i low: all registers, outputs, FSM hold; pulse stretches only as enable is low.
REQ-024 Delay taps pass data unmodified, independent of FSM.

Reset
REQ-025 Reset SHALL set FSM IDLE, all flags/pulse 0, rxd taps 64'h0707070707070707, rxc taps 8'hFF (idle).
REQ-026 Reset mid-frame: frame discarded by parser; parsing resumes at next valid start.

Configuration
REQ-027 Macro PTP_RX_VLAN_PARSE_EN defined: single 802.1Q tag (0x8100) parsed per REQ-017.
REQ-028 Macro undefined: VLAN state absent; tagged frames report is_ptp_message_o=0.

Verification
REQ-029 Untagged Sync, word2 lanes4-6 = 88 F7 00 -> pulse at t+1, is_ptp=1, type=0 at t+3, rxd_o start word at t+4.
REQ-030 Untagged Delay_Req type 1 then IPv4 frame (0x0800) -> second pulse clears flags; is_ptp stays 0.
REQ-031 Tagged frame, 81 00 tag, word3 = 88 F7 08 -> macro on: is_ptp=1, type=8 at t+4; macro off: is_ptp=0.
REQ-032 /T/ in word2 lane 3 -> FSM IDLE, is_ptp=0; /E/ mid-body -> frame_err_o=1 until next pulse.
REQ-033 rx_clk_en_i toggling 1-of-2 cycles, Sync frame -> identical results counted in enabled cycles; reset asserted at word 2 -> all outputs reset values, next frame parsed normally.
